// File: rtl/mux_varredura.sv
// rtl/mux_varredura.sv - registered channel mux with manual select and masked round-robin scan
module mux_varredura #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int DWELL = 4,
  localparam int SW   = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] d,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic [N-1:0]   mask,
  input  logic           en,
  output logic [W-1:0]   y,
  output logic [SW-1:0]  ch,
  output logic           wrap,
  output logic           err
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  logic [SW-1:0]  nxt_ch;
  logic           cur_elig;
  logic [W-1:0]   cur_data;
  logic [W-1:0]   sel_data;
  logic           sel_ok;
  logic           dwell_done;

  // Next eligible channel strictly after ch_q, wrapping; falls back to ch_q itself
  // when it is the only eligible one (single-channel scan).
  always_comb begin
    logic           found;
    int             idx;
    logic [N-1:0]   msh;
    nxt_ch = ch_q;
    found  = 1'b0;
    idx    = 0;
    msh    = '0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(ch_q) + i;
      if (idx >= N) idx = idx - N;
      msh = mask >> idx;
      if (!found && msh[0]) begin
        nxt_ch = SW'(idx);
        found  = 1'b1;
      end
    end
  end

  // Data and eligibility lookups for the current channel and the manual select.
  always_comb begin
    logic [N*W-1:0] dsh_cur;
    logic [N*W-1:0] dsh_sel;
    logic [N-1:0]   msh_cur;
    logic [31:0]    sel_ext;
    sel_ext    = 32'(sel);
    sel_ok     = (sel_ext < 32'(N));
    dsh_cur    = d >> (int'(ch_q) * W);
    dsh_sel    = d >> (int'(sel) * W);
    msh_cur    = mask >> ch_q;
    cur_data   = dsh_cur[W-1:0];
    sel_data   = dsh_sel[W-1:0];
    cur_elig   = msh_cur[0];
    dwell_done = (cnt_q == CW'(DWELL - 1));
  end

  // Next-state decision: freeze, manual select, or one scan step.
  always_comb begin
    y_d    = y_q;
    ch_d   = ch_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (en) begin
      if (!mode) begin
        cnt_d = '0;
        if (sel_ok) begin
          y_d  = sel_data;
          ch_d = sel;
        end else begin
          y_d   = '0;
          err_d = 1'b1;
        end
      end else if (mask == '0) begin
        y_d   = '0;
        cnt_d = '0;
      end else if (!cur_elig) begin
        // Channel lost eligibility mid-dwell: skip it at once, emit a zero sample.
        y_d    = '0;
        ch_d   = nxt_ch;
        cnt_d  = '0;
        wrap_d = (nxt_ch <= ch_q);
      end else begin
        y_d = cur_data;
        if (dwell_done) begin
          ch_d   = nxt_ch;
          cnt_d  = '0;
          wrap_d = (nxt_ch <= ch_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      ch_q   <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      y_q    <= y_d;
      ch_q   <= ch_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign y    = y_q;
  assign ch   = ch_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule
